echo_request_serializer: RTL and testbench

Downstream stage of the echo request packer. Consumes one 192-bit tagged request message per `pipe$enq` handshake and emits it as a stream of 32-bit beats (one header word, then payload words) toward the host transport port. Messages with an unknown method tag are dropped and counted. An optional one-message prefetch register hides the inter-message bubble.

---
 rtl/echo_request_serializer.sv | 221 ++++++++++++++++++++++
 tb/tb_echo_request_serializer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_request_serializer.sv
// echo_request_serializer
// Takes one 192-bit tagged request per pipe_enq handshake and sends it out as
// 32-bit beats: first a header word {len, tag[15:0]}, then the payload words.
// Messages with an unknown tag are dropped, and a saturating error counter
// records each one.
// Optional feature macro: ECHO_SERIALIZER_PREFETCH_EN adds a one-message
// holding register. While the current message is being sent, the next one
// waits in that register, so consecutive messages leave with no idle cycle.
module echo_request_serializer (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         pipe_enq__ENA,
  input  logic [191:0] pipe_enq_v,
  output logic         pipe_enq__RDY,
  output logic         out_beat__ENA,
  output logic [31:0]  out_beat_data,
  output logic         out_beat_last,
  input  logic         out_beat__RDY,
  output logic [15:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  // Only the low 16 tag bits go out in the header, and the tag has already
  // been decoded into len. The stored form is therefore {words 5..1, tag[15:0]}.
  localparam int unsigned MSG_W = 176;

  function automatic logic [MSG_W-1:0] pack_msg(input logic [191:0] v);
    return {v[191:32], v[15:0]};
  endfunction

  function automatic logic [1:0] len_of(input logic [31:0] tag);
    return (tag == 32'd2) ? 2'd3 : 2'd2;
  endfunction

  state_t             state_q, state_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         len_q, len_d;
  logic [15:0]        err_q, err_d;

  logic               enq_fire;
  logic               beat_fire;
  logic               tag_known;
  logic               at_last;
  logic               last_fire;
  logic [2:0]         word_sel;
  logic [31:0]        payload_word;

`ifdef ECHO_SERIALIZER_PREFETCH_EN
  logic [MSG_W-1:0]   hold_q, hold_d;
  logic [1:0]         hold_len_q, hold_len_d;
  logic               hold_valid_q, hold_valid_d;

  // With prefetch, a message can be taken whenever the holding slot is free.
  assign pipe_enq__RDY = nRST && !hold_valid_q;
`else
  // Without prefetch, a message is taken only while nothing is being sent.
  assign pipe_enq__RDY = nRST && (state_q == IDLE);
`endif

  assign tag_known = (pipe_enq_v[31:0] == 32'd1) || (pipe_enq_v[31:0] == 32'd2);
  assign enq_fire  = pipe_enq__ENA && pipe_enq__RDY;
  assign beat_fire = out_beat__ENA && out_beat__RDY;
  assign at_last   = (idx_q == (len_q - 2'd1));
  assign last_fire = (state_q == PAYLOAD) && beat_fire && at_last;
  assign err_count = err_q;

  // Tag-1 payload sits in words 1..2 and tag-2 payload in words 3..5.
  assign word_sel = (len_q == 2'd3) ? ({1'b0, idx_q} + 3'd3) : ({1'b0, idx_q} + 3'd1);

  // Select the payload word for the current beat index.
  always_comb begin
    // NOTE: give every combinational output a default value first, so that
    // no path through the case statements can infer a latch.
    payload_word = 32'd0;
    case (word_sel)
      3'd1:    payload_word = msg_q[47:16];
      3'd2:    payload_word = msg_q[79:48];
      3'd3:    payload_word = msg_q[111:80];
      3'd4:    payload_word = msg_q[143:112];
      3'd5:    payload_word = msg_q[175:144];
      default: payload_word = 32'd0;
    endcase
  end

  // Beat outputs depend only on registered state, so they stay stable during a stall.
  always_comb begin
    out_beat__ENA = 1'b0;
    out_beat_data = 32'd0;
    out_beat_last = 1'b0;
    case (state_q)
      HEADER: begin
        out_beat__ENA = 1'b1;
        out_beat_data = {14'd0, len_q, msg_q[15:0]};
      end
      PAYLOAD: begin
        out_beat__ENA = 1'b1;
        out_beat_data = payload_word;
        out_beat_last = at_last;
      end
      default: ;
    endcase
  end

  // Next-state logic: message capture, beat sequencing and error counting.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    idx_d   = idx_q;
    len_d   = len_q;
    err_d   = err_q;
`ifdef ECHO_SERIALIZER_PREFETCH_EN
    hold_d       = hold_q;
    hold_len_d   = hold_len_q;
    hold_valid_d = hold_valid_q;
`endif

    if (enq_fire && !tag_known && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (enq_fire && tag_known) begin
          msg_d   = pack_msg(pipe_enq_v);
          len_d   = len_of(pipe_enq_v[31:0]);
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (beat_fire) begin
          idx_d   = 2'd0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (beat_fire) begin
          idx_d = idx_q + 2'd1;
          if (at_last) begin
            idx_d   = 2'd0;
            state_d = IDLE;
`ifdef ECHO_SERIALIZER_PREFETCH_EN
            if (hold_valid_q) begin
              msg_d        = hold_q;
              len_d        = hold_len_q;
              hold_valid_d = 1'b0;
              state_d      = HEADER;
            end else if (enq_fire && tag_known) begin
              msg_d   = pack_msg(pipe_enq_v);
              len_d   = len_of(pipe_enq_v[31:0]);
              state_d = HEADER;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef ECHO_SERIALIZER_PREFETCH_EN
    // A message arriving during serialization is parked, unless the final
    // beat leaves at the same edge; in that case it is loaded directly above.
    if (enq_fire && tag_known && (state_q != IDLE) && !(last_fire && !hold_valid_q)) begin
      hold_d       = pack_msg(pipe_enq_v);
      hold_len_d   = len_of(pipe_enq_v[31:0]);
      hold_valid_d = 1'b1;
    end
`else
    if (last_fire) begin
      idx_d = 2'd0;
    end
`endif
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    if (!nRST) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      len_q   <= 2'd0;
      err_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  // Message payload storage; contents are qualified by the state/valid bits.
  always_ff @(posedge CLK) begin
    // NOTE: wide data registers are left unreset; nothing reads them until a
    // capture has set the matching state or valid bit.
    msg_q <= msg_d;
  end

`ifdef ECHO_SERIALIZER_PREFETCH_EN
  // Holding slot valid flag, cleared by reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hold_valid_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
    end
  end

  // Holding slot contents.
  always_ff @(posedge CLK) begin
    hold_q     <= hold_d;
    hold_len_q <= hold_len_d;
  end
`endif

endmodule

// File: tb/tb_echo_request_serializer.sv
// Directed testbench for echo_request_serializer. Expected beats are written
// as hand-computed constants. The back-to-back check uses the timing that
// matches whether ECHO_SERIALIZER_PREFETCH_EN is defined.
module tb_echo_request_serializer;

  logic         clk;
  logic         n_rst;
  logic         enq_ena;
  logic [191:0] enq_v;
  logic         enq_rdy;
  logic         beat_ena;
  logic [31:0]  beat_data;
  logic         beat_last;
  logic         beat_rdy;
  logic [15:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  echo_request_serializer dut (
    .CLK           (clk),
    .nRST          (n_rst),
    .pipe_enq__ENA (enq_ena),
    .pipe_enq_v    (enq_v),
    .pipe_enq__RDY (enq_rdy),
    .out_beat__ENA (beat_ena),
    .out_beat_data (beat_data),
    .out_beat_last (beat_last),
    .out_beat__RDY (beat_rdy),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds a request: [31:0] tag, then words 1..5.
  function automatic logic [191:0] mk(input logic [31:0] tag, input logic [31:0] w1,
                                      input logic [31:0] w2, input logic [31:0] w3,
                                      input logic [31:0] w4, input logic [31:0] w5);
    return {w5, w4, w3, w2, w1, tag};
  endfunction

  // Expected beat packed as {ena, last, data}.
  function automatic logic [33:0] bt(input logic ena, input logic last, input logic [31:0] d);
    return {ena, last, d};
  endfunction

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; enq_ena = 1'b0; enq_v = '0; beat_rdy = 1'b1;
    tick(); tick();
    n_cmp++;
    if (enq_rdy !== 1'b0) begin
      n_bad++; $display("FAIL reset_enq_rdy got=%b exp=0", enq_rdy);
    end
    n_cmp++;
    if ({beat_ena, beat_last, beat_data} !== 34'd0) begin
      n_bad++; $display("FAIL reset_beat got=%h exp=0", {beat_ena, beat_last, beat_data});
    end
    n_cmp++;
    if (err_count !== 16'd0) begin
      n_bad++; $display("FAIL reset_err got=%h exp=0000", err_count);
    end
    n_rst = 1'b1;
    tick();
    n_cmp++;
    if (enq_rdy !== 1'b1) begin
      n_bad++; $display("FAIL idle_enq_rdy got=%b exp=1", enq_rdy);
    end
  endtask

  task automatic test_tag1();
    logic [33:0] exp_b [3];
    logic        exp_rdy;
    exp_b[0] = bt(1'b1, 1'b0, 32'h0002_0001);
    exp_b[1] = bt(1'b1, 1'b0, 32'h0000_000A);
    exp_b[2] = bt(1'b1, 1'b1, 32'h0000_000B);
`ifdef ECHO_SERIALIZER_PREFETCH_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    beat_rdy = 1'b1;
    enq_v = mk(32'd1, 32'hA, 32'hB, 32'd0, 32'd0, 32'd0);
    enq_ena = 1'b1;
    tick();
    enq_ena = 1'b0;
    n_cmp++;
    if (enq_rdy !== exp_rdy) begin
      n_bad++; $display("FAIL tag1_busy_enq_rdy got=%b exp=%b", enq_rdy, exp_rdy);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({beat_ena, beat_last, beat_data} !== exp_b[i]) begin
        n_bad++; $display("FAIL tag1_beat%0d got=%h exp=%h", i, {beat_ena, beat_last, beat_data}, exp_b[i]);
      end
      tick();
    end
    n_cmp++;
    if (beat_ena !== 1'b0) begin
      n_bad++; $display("FAIL tag1_idle_after got=%b exp=0", beat_ena);
    end
  endtask

  task automatic test_tag2_stall();
    logic [33:0] exp_b [4];
    exp_b[0] = bt(1'b1, 1'b0, 32'h0003_0002);
    exp_b[1] = bt(1'b1, 1'b0, 32'h0000_0011);
    exp_b[2] = bt(1'b1, 1'b0, 32'h0000_0022);
    exp_b[3] = bt(1'b1, 1'b1, 32'h0000_0033);
    beat_rdy = 1'b1;
    enq_v = mk(32'd2, 32'd0, 32'd0, 32'h11, 32'h22, 32'h33);
    enq_ena = 1'b1;
    tick();
    enq_ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat_rdy = 1'b0;
      n_cmp++;
      if ({beat_ena, beat_last, beat_data} !== exp_b[i]) begin
        n_bad++; $display("FAIL tag2_beat%0d got=%h exp=%h", i, {beat_ena, beat_last, beat_data}, exp_b[i]);
      end
      tick();
      n_cmp++;
      if ({beat_ena, beat_last, beat_data} !== exp_b[i]) begin
        n_bad++; $display("FAIL tag2_hold%0d got=%h exp=%h", i, {beat_ena, beat_last, beat_data}, exp_b[i]);
      end
      beat_rdy = 1'b1;
      tick();
    end
    n_cmp++;
    if (beat_ena !== 1'b0) begin
      n_bad++; $display("FAIL tag2_idle_after got=%b exp=0", beat_ena);
    end
  endtask

  task automatic test_bad_tags();
    beat_rdy = 1'b1;
    enq_ena = 1'b1;
    enq_v = mk(32'd7, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    tick();
    n_cmp++;
    if ({beat_ena, err_count} !== {1'b0, 16'd1}) begin
      n_bad++; $display("FAIL bad_tag7 got ena=%b err=%h exp ena=0 err=0001", beat_ena, err_count);
    end
    enq_v = mk(32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    tick();
    n_cmp++;
    if ({beat_ena, err_count} !== {1'b0, 16'd2}) begin
      n_bad++; $display("FAIL bad_tag0 got ena=%b err=%h exp ena=0 err=0002", beat_ena, err_count);
    end
    // The low 16 bits look like tag 1, but the full 32-bit compare must reject it.
    enq_v = mk(32'h0001_0001, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    tick();
    n_cmp++;
    if ({beat_ena, err_count} !== {1'b0, 16'd3}) begin
      n_bad++; $display("FAIL bad_tag_hi got ena=%b err=%h exp ena=0 err=0003", beat_ena, err_count);
    end
    enq_v = mk(32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 65531; i++) tick();
    n_cmp++;
    if (err_count !== 16'hFFFE) begin
      n_bad++; $display("FAIL err_fffe got=%h exp=fffe", err_count);
    end
    tick();
    n_cmp++;
    if (err_count !== 16'hFFFF) begin
      n_bad++; $display("FAIL err_ffff got=%h exp=ffff", err_count);
    end
    tick();
    n_cmp++;
    if (err_count !== 16'hFFFF) begin
      n_bad++; $display("FAIL err_saturate got=%h exp=ffff", err_count);
    end
    enq_ena = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp_b [9];
    logic [33:0] hd, p0, p1, idl;
    hd  = bt(1'b1, 1'b0, 32'h0002_0001);
    p0  = bt(1'b1, 1'b0, 32'h0000_0005);
    p1  = bt(1'b1, 1'b1, 32'h0000_0006);
    idl = 34'd0;
`ifdef ECHO_SERIALIZER_PREFETCH_EN
    exp_b[0] = hd; exp_b[1] = p0; exp_b[2] = p1;
    exp_b[3] = hd; exp_b[4] = p0; exp_b[5] = p1;
    exp_b[6] = hd; exp_b[7] = p0; exp_b[8] = p1;
`else
    exp_b[0] = hd; exp_b[1] = p0; exp_b[2] = p1;
    exp_b[3] = idl; exp_b[4] = hd; exp_b[5] = p0;
    exp_b[6] = p1; exp_b[7] = idl; exp_b[8] = hd;
`endif
    beat_rdy = 1'b1;
    enq_v = mk(32'd1, 32'h5, 32'h6, 32'd0, 32'd0, 32'd0);
    enq_ena = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if ({beat_ena, beat_last, beat_data} !== exp_b[i]) begin
        n_bad++; $display("FAIL b2b_cycle%0d got=%h exp=%h", i, {beat_ena, beat_last, beat_data}, exp_b[i]);
      end
      tick();
    end
    enq_ena = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if ({beat_ena, enq_rdy} !== 2'b01) begin
      n_bad++; $display("FAIL b2b_drain got ena=%b rdy=%b exp ena=0 rdy=1", beat_ena, enq_rdy);
    end
  endtask

  task automatic test_reset_mid();
    logic [33:0] exp_b [3];
    beat_rdy = 1'b1;
    enq_v = mk(32'd2, 32'd0, 32'd0, 32'h11, 32'h22, 32'h33);
    enq_ena = 1'b1;
    tick();
    enq_ena = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({beat_ena, beat_last, beat_data} !== bt(1'b1, 1'b0, 32'h22)) begin
      n_bad++; $display("FAIL mid_pre_reset got=%h exp=%h", {beat_ena, beat_last, beat_data}, bt(1'b1, 1'b0, 32'h22));
    end
    n_rst = 1'b0;
    tick();
    n_cmp++;
    if ({beat_ena, beat_last, beat_data, err_count, enq_rdy} !== 51'd0) begin
      n_bad++; $display("FAIL mid_reset got ena=%b last=%b data=%h err=%h rdy=%b exp all 0",
                        beat_ena, beat_last, beat_data, err_count, enq_rdy);
    end
    n_rst = 1'b1;
    tick();
    n_cmp++;
    if ({beat_ena, enq_rdy} !== 2'b01) begin
      n_bad++; $display("FAIL mid_post_reset got ena=%b rdy=%b exp ena=0 rdy=1", beat_ena, enq_rdy);
    end
    exp_b[0] = bt(1'b1, 1'b0, 32'h0002_0001);
    exp_b[1] = bt(1'b1, 1'b0, 32'h0000_0007);
    exp_b[2] = bt(1'b1, 1'b1, 32'h0000_0008);
    enq_v = mk(32'd1, 32'h7, 32'h8, 32'd0, 32'd0, 32'd0);
    enq_ena = 1'b1;
    tick();
    enq_ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({beat_ena, beat_last, beat_data} !== exp_b[i]) begin
        n_bad++; $display("FAIL mid_next_beat%0d got=%h exp=%h", i, {beat_ena, beat_last, beat_data}, exp_b[i]);
      end
      tick();
    end
    n_cmp++;
    if (beat_ena !== 1'b0) begin
      n_bad++; $display("FAIL mid_next_idle got=%b exp=0", beat_ena);
    end
  endtask

  initial begin
    n_rst = 1'b0; enq_ena = 1'b0; enq_v = '0; beat_rdy = 1'b1;
    test_reset();
    test_tag1();
    test_tag2_stall();
    test_bad_tags();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
